latched_chip_select_decoder: RTL and testbench
==============================================

LATCHED_CHIP_SELECT_DECODER -- requirements
Module: latched_chip_select_decoder

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, meaning address width; output count N = 2**ADDR_W; legal range 1..6.
REQ-002 SHALL have parameter HOLD_CYC, default 2, meaning cycles a select stays asserted; legal range 1..255.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 SHALL have port addr, input, ADDR_W, the select address, sampled only on accept.
REQ-006 SHALL have port en, input, 3; en[2] is active-high, en[1] and en[0] are active-low; enable_ok = en[2] & ~en[1] & ~en[0].
REQ-007 SHALL have port strobe, input, 1, a request to start a select cycle.
REQ-008 SHALL have port abort, input, 1, which ends an active assertion early.
REQ-009 SHALL have port clr_err, input, 1, which clears the overrun flag.
REQ-010 SHALL have port sel_n, output, N, active-low one-hot chip selects; all 1 means none selected.
REQ-011 SHALL have port busy, output, 1, high from accept through recovery.
REQ-012 SHALL have port done, output, 1, a one-cycle completion pulse.
REQ-013 SHALL have port overrun, output, 1, sticky: a request arrived while busy.

Function
REQ-014 SHALL implement FSM states IDLE, ASSERT and RECOVER.
REQ-015 Accept SHALL be strobe & enable_ok in IDLE: on that edge, latch addr, load hold counter with HOLD_CYC-1, go to ASSERT.
REQ-016 In ASSERT, sel_n[latched addr] SHALL be 0 and all other bits 1; outputs are registered, so the first low cycle is the cycle after the accept edge.
REQ-017 ASSERT SHALL last exactly HOLD_CYC cycles: decrement the counter each cycle, leave for RECOVER when it reaches 0.
REQ-018 abort high in ASSERT SHALL move to RECOVER on the next edge, regardless of the counter; abort is ignored in IDLE and RECOVER.
REQ-019 RECOVER SHALL last exactly 1 cycle with sel_n all ones and done=1, then return to IDLE.
REQ-020 busy SHALL be 1 in ASSERT and RECOVER and 0 in IDLE.
REQ-021 strobe in IDLE with enable_ok=0 SHALL be ignored: no state change, no overrun.
REQ-022 strobe while busy=1 SHALL set overrun on the next edge; the request is dropped and addr is not re-latched.
REQ-023 clr_err SHALL clear overrun on the next edge; if clr_err and a set condition occur together, set wins.
REQ-024 Changes to addr or en after accept SHALL NOT affect the current cycle.
REQ-025 A strobe in the IDLE cycle right after RECOVER SHALL be accepted, giving a minimum of one deselected cycle between selects.
REQ-026 At most one sel_n bit SHALL be 0 in any cycle.

Reset
REQ-027 rst SHALL, on the edge, force IDLE, sel_n = all ones, busy=0, done=0, overrun=0, counter=0 and latched address=0.
REQ-028 rst during ASSERT SHALL deassert the select on that same edge; rst has priority over all other inputs.

Structure
REQ-029 A shared package decoder_pkg SHALL hold the FSM state enum and the enable-polarity constant EN_OK_PATTERN = 3'b100.
REQ-030 SHALL use one combinational sub-module, onehot_decode (parameter ADDR_W, active-low N-bit output), feeding the sel_n register.
REQ-031 The counter width SHALL be $clog2(HOLD_CYC+1).

Verification (ADDR_W=3, HOLD_CYC=2)
REQ-032 Basic select: en=3'b100, addr=5, one-cycle strobe at T -> sel_n=8'b1101_1111 in T+1..T+2; sel_n=FF, done=1 at T+3; busy=0 at T+4.
REQ-033 Disabled request: en=3'b110, strobe -> sel_n stays FF, busy=0, overrun=0.
REQ-034 Overrun: strobe at T (addr=2), strobe at T+1 (addr=7) -> only sel_n[2] low; overrun=1 from T+2 until clr_err.
REQ-035 Abort: accept addr=0 at T, abort high in T+1 -> sel_n[0] low only in T+1; done=1 in T+2.
REQ-036 Reset mid-cycle: rst during ASSERT with addr=3 -> next cycle sel_n=FF, busy=0, state IDLE; back-to-back strobe right after RECOVER is accepted.

Source files
------------

// File: rtl/decoder_pkg.sv
// Shared types and constants for the latched chip-select decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   state_t        - controller states IDLE / ASSERT / RECOVER
//   EN_OK_PATTERN  - en value that qualifies a request ({hi, lo, lo})
//   enable_ok()    - helper that applies the enable polarity
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    RECOVER = 2'd2
  } state_t;

  // en[2] is active-high, en[1:0] are active-low, so the only qualifying
  // pattern is 3'b100.
  localparam logic [2:0] EN_OK_PATTERN = 3'b100;

  function automatic logic enable_ok(input logic [2:0] en);
    return (en == EN_OK_PATTERN);
  endfunction

endpackage

// File: rtl/onehot_decode.sv
// Combinational address to active-low one-hot decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows inputs.
//
// Ports:
//   addr   - index of the bit to pull low
//   act    - when low, every output bit stays high (nothing selected)
//   sel_n  - active-low one-hot result, 2**ADDR_W bits
module onehot_decode #(
  parameter int ADDR_W = 3
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   act,
  output logic [2**ADDR_W-1:0]   sel_n
);

  always_comb begin
    sel_n = '1;
    if (act) begin
      sel_n[addr] = 1'b0;
    end
  end

endmodule

// File: rtl/latched_chip_select_decoder.sv
// Latched chip-select decoder: a qualified strobe latches addr and drives one
// active-low select for HOLD_CYC cycles, then a one-cycle recovery with done.
// Latency: select goes low the cycle after the accept edge; requests while busy are dropped and flagged in overrun.
//
// Ports:
//   clk      - single clock, rising edge
//   rst      - synchronous active-high reset, highest priority
//   addr     - select address, captured only on accept
//   en       - enables, {active-high, active-low, active-low}
//   strobe   - request to start a select cycle
//   abort    - ends an ongoing assertion on the next edge
//   clr_err  - clears overrun (a simultaneous new overrun wins)
//   sel_n    - registered active-low one-hot chip selects
//   busy     - high from accept through recovery
//   done     - one-cycle pulse during recovery
//   overrun  - sticky: a strobe arrived while busy
module latched_chip_select_decoder
  import decoder_pkg::*;
#(
  parameter int ADDR_W   = 3,
  parameter int HOLD_CYC = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [2:0]             en,
  input  logic                   strobe,
  input  logic                   abort,
  input  logic                   clr_err,
  output logic [2**ADDR_W-1:0]   sel_n,
  output logic                   busy,
  output logic                   done,
  output logic                   overrun
);

  localparam int N     = 2**ADDR_W;
  localparam int CNT_W = $clog2(HOLD_CYC + 1);

  // The counter holds "assert cycles remaining after this one", so a load of
  // HOLD_CYC-1 followed by an exit at zero gives exactly HOLD_CYC cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [N-1:0]        sel_n_q, sel_n_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                overrun_q, overrun_d;
  logic                busy_now;

  assign busy_now = (state_q != IDLE);

  // Next-state, counter and address capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;

    case (state_q)
      IDLE: begin
        if (strobe && enable_ok(en)) begin
          state_d = ASSERT;
          cnt_d   = CNT_LOAD;
          addr_d  = addr;
        end
      end
      ASSERT: begin
        if (abort || (cnt_q == '0)) begin
          state_d = RECOVER;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      RECOVER: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Output next-values are derived from the next state so the registered
  // outputs line up with the state they describe.
  always_comb begin
    busy_d = (state_d != IDLE);
    done_d = (state_d == RECOVER);

    // A set condition in the same cycle as clr_err keeps the flag high.
    overrun_d = overrun_q;
    if (strobe && busy_now) begin
      overrun_d = 1'b1;
    end else if (clr_err) begin
      overrun_d = 1'b0;
    end
  end

  // Decoding the next address (not the latched one) lets the select go low
  // in the first ASSERT cycle without an extra pipeline stage.
  onehot_decode #(
    .ADDR_W (ADDR_W)
  ) u_onehot_decode (
    .addr  (addr_d),
    .act   (state_d == ASSERT),
    .sel_n (sel_n_d)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      sel_n_q   <= '1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      sel_n_q   <= sel_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      overrun_q <= overrun_d;
    end
  end

  assign sel_n   = sel_n_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_latched_chip_select_decoder.sv
// Self-checking bench for latched_chip_select_decoder (ADDR_W=3, HOLD_CYC=2).
// A cycle-level reference model tracks remaining select cycles, recovery and
// the overrun flag; a compare process checks every cycle, and the directed
// sequence adds literal expectations taken from the select-cycle rules.
module tb_latched_chip_select_decoder;

  localparam int ADDR_W = 3;
  localparam int HOLD   = 2;
  localparam int N      = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [2:0]    addr;
  logic [2:0]    en;
  logic          strobe;
  logic          abort;
  logic          clr_err;
  logic [N-1:0]  sel_n;
  logic          busy;
  logic          done;
  logic          overrun;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Reference model state.
  int         m_left = 0;   // select cycles still to come
  bit         m_rec  = 0;   // in the single recovery cycle
  bit         m_ovr  = 0;
  int         m_addr = 0;

  always #5 clk = ~clk;

  latched_chip_select_decoder #(
    .ADDR_W   (ADDR_W),
    .HOLD_CYC (HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .addr    (addr),
    .en      (en),
    .strobe  (strobe),
    .abort   (abort),
    .clr_err (clr_err),
    .sel_n   (sel_n),
    .busy    (busy),
    .done    (done),
    .overrun (overrun)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: advances on each rising edge from the inputs applied before it.
  always @(posedge clk) begin
    bit was_busy;
    if (rst) begin
      m_left = 0;
      m_rec  = 0;
      m_ovr  = 0;
      m_addr = 0;
    end else begin
      was_busy = (m_left > 0) || m_rec;
      if (strobe && was_busy) m_ovr = 1;
      else if (clr_err)       m_ovr = 0;

      if (m_rec) begin
        m_rec = 0;
      end else if (m_left > 0) begin
        if (abort || m_left == 1) begin
          m_left = 0;
          m_rec  = 1;
        end else begin
          m_left = m_left - 1;
        end
      end else if (strobe && en[2] && !en[1] && !en[0]) begin
        m_left = HOLD;
        m_addr = int'(addr);
      end
    end
  end

  // Compare process: every cycle, mid-period.
  always @(negedge clk) begin
    logic [N-1:0] exp_sel;
    if (chk_en) begin
      exp_sel = '1;
      if (m_left > 0) exp_sel[m_addr] = 1'b0;
      chk("model_sel_n",   32'(sel_n),   32'(exp_sel));
      chk("model_busy",    32'(busy),    32'((m_left > 0) || m_rec));
      chk("model_done",    32'(done),    32'(m_rec));
      chk("model_overrun", 32'(overrun), 32'(m_ovr));
      chk("onehot_at_most_one", 32'($countones(~sel_n) <= 1), 32'd1);
    end
  end

  // One clock edge, then stop mid-period where checks and input changes happen.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [N-1:0] exp_sel;
    rst = 1'b1; addr = '0; en = 3'b100; strobe = 1'b0; abort = 1'b0; clr_err = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_sel_n",   32'(sel_n),   32'hFF);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_done",    32'(done),    32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;
    tick();

    // Basic select, addr/en changed right after accept must not matter.
    addr = 3'd5; en = 3'b100; strobe = 1'b1;
    tick();
    chk("basic_t1_sel", 32'(sel_n), 32'hDF);
    chk("basic_t1_busy", 32'(busy), 32'd1);
    strobe = 1'b0; addr = 3'd1; en = 3'b011;
    tick();
    chk("basic_t2_sel", 32'(sel_n), 32'hDF);
    tick();
    chk("basic_t3_sel", 32'(sel_n), 32'hFF);
    chk("basic_t3_done", 32'(done), 32'd1);
    tick();
    chk("basic_t4_busy", 32'(busy), 32'd0);
    chk("basic_t4_done", 32'(done), 32'd0);

    // Disabled request.
    en = 3'b110; strobe = 1'b1;
    tick();
    chk("dis_sel", 32'(sel_n), 32'hFF);
    chk("dis_busy", 32'(busy), 32'd0);
    chk("dis_overrun", 32'(overrun), 32'd0);
    strobe = 1'b0; en = 3'b100;
    tick();

    // Overrun: second strobe while busy is dropped and flagged.
    addr = 3'd2; strobe = 1'b1;
    tick();
    addr = 3'd7;
    tick();
    chk("ovr_sel", 32'(sel_n), 32'hFB);
    chk("ovr_flag", 32'(overrun), 32'd1);
    strobe = 1'b0;
    tick();
    chk("ovr_done", 32'(done), 32'd1);
    tick();
    chk("ovr_sticky", 32'(overrun), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);

    // Set and clear in the same cycle: set wins.
    addr = 3'd4; strobe = 1'b1;
    tick();
    clr_err = 1'b1;
    tick();
    chk("setwins_flag", 32'(overrun), 32'd1);
    chk("setwins_sel", 32'(sel_n), 32'hEF);
    strobe = 1'b0; clr_err = 1'b0;
    tick();
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("setwins_cleared", 32'(overrun), 32'd0);

    // Abort after one assert cycle.
    addr = 3'd0; strobe = 1'b1;
    tick();
    chk("abort_t1_sel", 32'(sel_n), 32'hFE);
    strobe = 1'b0; abort = 1'b1;
    tick();
    chk("abort_t2_sel", 32'(sel_n), 32'hFF);
    chk("abort_t2_done", 32'(done), 32'd1);
    abort = 1'b0;
    tick();
    // Abort in IDLE has no effect.
    abort = 1'b1;
    tick();
    chk("abort_idle_busy", 32'(busy), 32'd0);
    abort = 1'b0;

    // Reset during ASSERT.
    addr = 3'd3; strobe = 1'b1;
    tick();
    chk("rstmid_sel_before", 32'(sel_n), 32'hF7);
    strobe = 1'b0; rst = 1'b1;
    tick();
    chk("rstmid_sel", 32'(sel_n), 32'hFF);
    chk("rstmid_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Strobe in the IDLE cycle right after RECOVER is accepted.
    addr = 3'd6; strobe = 1'b1;
    tick();
    strobe = 1'b0;
    tick();
    tick();
    chk("b2b_rec_done", 32'(done), 32'd1);
    tick();
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    addr = 3'd1; strobe = 1'b1;
    tick();
    chk("b2b_sel", 32'(sel_n), 32'hFD);
    chk("b2b_no_overrun", 32'(overrun), 32'd0);
    strobe = 1'b0;
    tick(); tick(); tick();

    // Every address selects exactly its own line.
    for (int a = 0; a < N; a++) begin
      addr = 3'(a); strobe = 1'b1;
      tick();
      exp_sel = '1;
      exp_sel[a] = 1'b0;
      chk("sweep_sel", 32'(sel_n), 32'(exp_sel));
      strobe = 1'b0;
      tick(); tick(); tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
